demorgan_checker: RTL and testbench
===================================

DEMORGAN_CHECKER -- requirements
Module: demorgan_checker

Interface
REQ-001 Parameter WIDTH, default 2, number of gate inputs per vector; legal range 1..8.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a truth-table sweep; sampled only in IDLE.
REQ-005 mode  input  2  identity under test: 00 NAND vs (~a)+(~b)..., 01 NOR vs (~a)(~b)..., 10 AND vs NOR-of-inverted-inputs, 11 OR vs NAND-of-inverted-inputs.
REQ-006 fault_en  input  1  enable injected mismatch; sampled with start.
REQ-007 fault_vec  input  WIDTH  vector at which rhs is inverted; sampled with start.
REQ-008 vec  output  WIDTH  current input vector applied to both sides.
REQ-009 lhs  output  1  reference-form result for vec under latched mode.
REQ-010 rhs  output  1  equivalent-form result for vec, inverted when latched fault_en and vec==latched fault_vec.
REQ-011 valid  output  1  high while lhs/rhs are being compared (SWEEP).
REQ-012 busy  output  1  high in SWEEP and DONE.
REQ-013 done  output  1  one-cycle pulse, high in DONE.
REQ-014 mismatch_count  output  WIDTH+1  number of vectors with lhs!=rhs in last sweep.
REQ-015 first_fail_vec  output  WIDTH  lowest vector that mismatched in last sweep; 0 if none.
REQ-016 equal  output  1  1 when last completed sweep had mismatch_count==0.

Function
REQ-017 FSM shall have states IDLE, SWEEP, DONE; IDLE->SWEEP on edge with start=1; SWEEP->DONE on edge where vec==2^WIDTH-1; DONE->IDLE next edge unconditionally.
REQ-018 On IDLE->SWEEP edge: mode, fault_en, fault_vec latched; vec=0; mismatch_count=0; first_fail_vec=0; equal=0.
REQ-019 In SWEEP, vec shall increment by 1 each edge; no wrap beyond 2^WIDTH-1 (state leaves SWEEP on that edge).
REQ-020 lhs/rhs shall be combinational from vec and latched mode/fault; N-input reductions over all WIDTH bits.
REQ-021 On each SWEEP edge with lhs!=rhs: mismatch_count+=1; if count was 0, first_fail_vec=vec.
REQ-022 Latency: start sampled at edge k -> vectors 0..2^WIDTH-1 compared at edges k+1..k+2^WIDTH; done high in cycle after edge k+2^WIDTH; IDLE after edge k+2^WIDTH+1.
REQ-023 On SWEEP->DONE edge: equal = (final mismatch_count==0), including mismatch at last vector.
REQ-024 mismatch_count, first_fail_vec, equal shall hold from DONE until next accepted start.
REQ-025 start while busy shall be ignored; latched mode/fault unchanged mid-sweep.
REQ-026 mismatch_count shall reach 2^WIDTH without overflow (fault cannot exceed 1, but width is fixed WIDTH+1).
REQ-027 valid=0 and lhs/rhs not counted outside SWEEP.

Reset
REQ-028 reset=1 shall immediately force IDLE; vec=0, valid=0, busy=0, done=0, mismatch_count=0, first_fail_vec=0, equal=0, latched mode=00, fault_en=0.
REQ-029 Reset mid-sweep shall abort with no done pulse; first start after deassertion begins a fresh sweep from vec=0.

Verification
REQ-030 WIDTH=2, mode=00, fault_en=0, start 1 cycle -> vec 0,1,2,3 on consecutive cycles, done 5 cycles after start edge, mismatch_count=0, equal=1.
REQ-031 WIDTH=2, mode=01, fault_en=1, fault_vec=2 -> mismatch_count=1, first_fail_vec=2, equal=0.
REQ-032 WIDTH=3, mode=11, fault_en=1, fault_vec=7 (last vector) -> 8 compare cycles, mismatch_count=1, first_fail_vec=7, equal=0, vec does not wrap.
REQ-033 WIDTH=2, start held high through sweep with mode changed to 10 mid-sweep -> results use original mode; second sweep begins only after return to IDLE.
REQ-034 Assert reset at vec=1 of a WIDTH=2 sweep -> outputs all 0 same cycle, no done; restart with mode=10 -> equal=1 after 4 vectors.
REQ-035 WIDTH=1, all four modes, fault_en=0 -> each sweep 2 vectors, equal=1.

Source files
------------

// File: rtl/demorgan_checker.sv
// demorgan_checker: sweeps every WIDTH-bit input vector. At each vector it
// compares a reference gate form (lhs) with its De Morgan equivalent (rhs).
// A mismatch can be injected on rhs at one vector to exercise the counters.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               request a sweep (sampled only in IDLE)
//   mode[1:0]           identity under test (latched with start)
//   fault_en, fault_vec inject an rhs inversion at fault_vec (latched with start)
//   vec                 vector currently applied to both sides
//   lhs, rhs            combinational results for vec under the latched setup
//   valid               high while lhs/rhs are being compared (SWEEP)
//   busy                high in SWEEP and DONE
//   done                one-cycle pulse in DONE
//   mismatch_count      mismatching vectors in the last sweep
//   first_fail_vec      lowest mismatching vector of the last sweep (0 if none)
//   equal               last completed sweep had no mismatch
module demorgan_checker #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             fault_en,
  input  logic [WIDTH-1:0] fault_vec,
  output logic [WIDTH-1:0] vec,
  output logic             lhs,
  output logic             rhs,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   mismatch_count,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             equal
);

  localparam int unsigned CW = WIDTH + 1;
  localparam logic [WIDTH-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic             fault_en_q;
  logic [WIDTH-1:0] fault_vec_q;
  logic             rhs_raw;
  logic             mis_c;

  // Reference form on lhs, De Morgan equivalent built from inverted inputs on rhs
  always_comb begin
    lhs     = 1'b0;
    rhs_raw = 1'b0;
    case (mode_q)
      2'b00: begin lhs = ~(&vec); rhs_raw =   |(~vec);  end
      2'b01: begin lhs = ~(|vec); rhs_raw =   &(~vec);  end
      2'b10: begin lhs =   &vec;  rhs_raw = ~(|(~vec)); end
      default: begin lhs = |vec;  rhs_raw = ~(&(~vec)); end
    endcase
    rhs   = rhs_raw ^ (fault_en_q && (vec == fault_vec_q));
    mis_c = lhs ^ rhs;
  end

  // Sweep controller and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mode_q         <= 2'b00;
      fault_en_q     <= 1'b0;
      fault_vec_q    <= '0;
      vec            <= '0;
      valid          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch_count <= '0;
      first_fail_vec <= '0;
      equal          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= SWEEP;
            mode_q         <= mode;
            fault_en_q     <= fault_en;
            fault_vec_q    <= fault_vec;
            vec            <= '0;
            mismatch_count <= '0;
            first_fail_vec <= '0;
            equal          <= 1'b0;
            valid          <= 1'b1;
            busy           <= 1'b1;
          end
        end
        SWEEP: begin
          if (mis_c) begin
            mismatch_count <= mismatch_count + CW'(1);
            if (mismatch_count == CW'(0)) first_fail_vec <= vec;
          end
          // Last vector: leave SWEEP without wrapping vec; include its own mismatch
          if (vec == LAST_VEC) begin
            state <= DONE;
            valid <= 1'b0;
            done  <= 1'b1;
            equal <= (mismatch_count == CW'(0)) && !mis_c;
          end else begin
            vec <= vec + WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_checker.sv
// Testbench for demorgan_checker: WIDTH=1, 2 and 3 instances share the stimulus.
// sel routes start to one instance and selects which outputs are observed.
module tb_demorgan_checker;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  int         sel;
  logic [1:0] mode;
  logic       fault_en;
  logic [2:0] fault_vec;

  logic start1, start2, start3;
  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);
  assign start3 = start && (sel == 3);

  logic [0:0] v1, f1;  logic [1:0] c1;
  logic [1:0] v2, f2;  logic [2:0] c2;
  logic [2:0] v3, f3;  logic [3:0] c3;
  logic l1, r1, va1, b1, d1, e1;
  logic l2, r2, va2, b2, d2, e2;
  logic l3, r3, va3, b3, d3, e3;

  demorgan_checker #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode), .fault_en(fault_en),
    .fault_vec(fault_vec[0:0]), .vec(v1), .lhs(l1), .rhs(r1), .valid(va1),
    .busy(b1), .done(d1), .mismatch_count(c1), .first_fail_vec(f1), .equal(e1));
  demorgan_checker #(.WIDTH(2)) u_w2 (
    .clk(clk), .reset(reset), .start(start2), .mode(mode), .fault_en(fault_en),
    .fault_vec(fault_vec[1:0]), .vec(v2), .lhs(l2), .rhs(r2), .valid(va2),
    .busy(b2), .done(d2), .mismatch_count(c2), .first_fail_vec(f2), .equal(e2));
  demorgan_checker #(.WIDTH(3)) u_w3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode), .fault_en(fault_en),
    .fault_vec(fault_vec), .vec(v3), .lhs(l3), .rhs(r3), .valid(va3),
    .busy(b3), .done(d3), .mismatch_count(c3), .first_fail_vec(f3), .equal(e3));

  // Observed outputs of the selected instance, zero-extended
  logic [2:0] vec_m, ffv_m;
  logic [3:0] cnt_m;
  logic       lhs_m, rhs_m, valid_m, busy_m, done_m, equal_m;
  always_comb begin
    vec_m = {1'b0, v2}; ffv_m = {1'b0, f2}; cnt_m = {1'b0, c2};
    lhs_m = l2; rhs_m = r2; valid_m = va2; busy_m = b2; done_m = d2; equal_m = e2;
    case (sel)
      1: begin
        vec_m = {2'b00, v1}; ffv_m = {2'b00, f1}; cnt_m = {2'b00, c1};
        lhs_m = l1; rhs_m = r1; valid_m = va1; busy_m = b1; done_m = d1; equal_m = e1;
      end
      3: begin
        vec_m = v3; ffv_m = f3; cnt_m = c3;
        lhs_m = l3; rhs_m = r3; valid_m = va3; busy_m = b3; done_m = d3; equal_m = e3;
      end
      default: ;
    endcase
  end

  typedef struct {
    int cnt;
    int ffv;
    bit eq;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference gate forms evaluated bit by bit
  function automatic logic m_lhs(input int w, input logic [1:0] md, input int v);
    logic all1, any1;
    all1 = 1'b1; any1 = 1'b0;
    for (int i = 0; i < w; i++) begin
      all1 &= v[i];
      any1 |= v[i];
    end
    case (md)
      2'b00: return !all1;
      2'b01: return !any1;
      2'b10: return all1;
      default: return any1;
    endcase
  endfunction

  // Equivalent forms expressed through the inverted inputs
  function automatic logic m_rhs(input int w, input logic [1:0] md, input int v,
                                 input logic fen, input int fv);
    logic any0, all0, r;
    any0 = 1'b0; all0 = 1'b1;
    for (int i = 0; i < w; i++) begin
      any0 |= !v[i];
      all0 &= !v[i];
    end
    case (md)
      2'b00: r = any0;
      2'b01: r = all0;
      2'b10: r = !any0;
      default: r = !all0;
    endcase
    return r ^ (fen && (v == fv));
  endfunction

  // Called at a falling edge; drives one sweep and checks every vector and the result
  task automatic run_sweep(input int w, input logic [1:0] md, input logic fen,
                           input int fv, input bit hold);
    int   n;
    exp_t e;
    n = 1 << w;
    sel = w; mode = md; fault_en = fen; fault_vec = 3'(fv); start = 1'b1;
    e.cnt = 0; e.ffv = 0;
    for (int v = 0; v < n; v++) begin
      if (m_lhs(w, md, v) != m_rhs(w, md, v, fen, fv)) begin
        if (e.cnt == 0) e.ffv = v;
        e.cnt++;
      end
    end
    e.eq = (e.cnt == 0);
    sbq.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("accept_busy", busy_m, 1);
    chk("accept_cnt_clear", cnt_m, 0);
    chk("accept_ffv_clear", ffv_m, 0);
    chk("accept_equal_clear", equal_m, 0);
    for (int i = 0; i < n; i++) begin
      chk("sweep_vec", vec_m, i);
      chk("sweep_valid", valid_m, 1);
      chk("sweep_done_low", done_m, 0);
      chk("sweep_lhs", lhs_m, m_lhs(w, md, i));
      chk("sweep_rhs", rhs_m, m_rhs(w, md, i, fen, fv));
      if (hold && i == 1) begin
        mode = 2'b10; fault_en = 1'b0; fault_vec = 3'd3;
      end
      @(negedge clk);
    end
    chk("done_pulse", done_m, 1);
    chk("done_valid_low", valid_m, 0);
    chk("done_busy", busy_m, 1);
    chk("done_vec_nowrap", vec_m, n - 1);
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk("result_count", cnt_m, e.cnt);
      chk("result_ffv", ffv_m, e.ffv);
      chk("result_equal", equal_m, e.eq);
    end
    @(negedge clk);
    chk("idle_done_low", done_m, 0);
    chk("idle_busy_low", busy_m, 0);
    chk("hold_count", cnt_m, e.cnt);
    chk("hold_ffv", ffv_m, e.ffv);
    chk("hold_equal", equal_m, e.eq);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = 2; mode = 2'b00; fault_en = 1'b0; fault_vec = 3'd0;
    repeat (2) @(negedge clk);
    for (int s = 1; s <= 3; s++) begin
      sel = s;
      #1;
      chk("rst_vec", vec_m, 0);
      chk("rst_valid", valid_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_count", cnt_m, 0);
      chk("rst_ffv", ffv_m, 0);
      chk("rst_equal", equal_m, 0);
      chk("rst_lhs_nand0", lhs_m, 1);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_sweep(2, 2'b00, 1'b0, 0, 1'b0);
    run_sweep(2, 2'b01, 1'b1, 2, 1'b0);
    run_sweep(3, 2'b11, 1'b1, 7, 1'b0);
    run_sweep(3, 2'b00, 1'b1, 0, 1'b0);
    // start held through the sweep, inputs changed mid-sweep; the second sweep follows
    run_sweep(2, 2'b00, 1'b1, 1, 1'b1);
    run_sweep(2, 2'b10, 1'b0, 0, 1'b0);

    // Reset in the middle of a sweep
    sel = 2; mode = 2'b00; fault_en = 1'b0; fault_vec = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_vec_before", vec_m, 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_vec", vec_m, 0);
    chk("abort_valid", valid_m, 0);
    chk("abort_busy", busy_m, 0);
    chk("abort_done", done_m, 0);
    chk("abort_count", cnt_m, 0);
    chk("abort_ffv", ffv_m, 0);
    chk("abort_equal", equal_m, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", done_m, 0);
      chk("abort_stays_idle", busy_m, 0);
    end
    run_sweep(2, 2'b10, 1'b0, 0, 1'b0);

    for (int m = 0; m < 4; m++) run_sweep(1, 2'(m), 1'b0, 0, 1'b0);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
